// File: rtl/ifns_decoder_arbiter.sv
// Round-robin shared IFNS 17->12 decoder with registered valid/ready output.
// Also holds the combinational single-error-correcting core it time-shares.

// IFNS core: Hamming SEC decode of a 17-bit word (position p = bit p-1).
// Parity sits at positions 1,2,4,8,16; data fills the rest in ascending order.
module decoderIFNS_12di_core (
    input  logic [16:0] code,
    output logic [11:0] data
);

    logic [4:0]  syn;
    logic [16:0] fixed;

    // Syndrome is the XOR of the positions of all set bits
    always_comb begin
        syn = '0;
        for (int p = 1; p <= 17; p++) begin
            if (code[p-1]) begin
                syn = syn ^ 5'(p);
            end
        end
    end

    // Flip the addressed bit; out-of-range syndromes leave the word as is
    always_comb begin
        fixed = code;
        for (int p = 1; p <= 17; p++) begin
            if (syn == 5'(p)) begin
                fixed[p-1] = ~code[p-1];
            end
        end
    end

    // Gather data positions 3,5,6,7,9..15,17 into bits 0..11
    always_comb begin
        data = {fixed[16], fixed[14], fixed[13], fixed[12],
                fixed[11], fixed[10], fixed[9],  fixed[8],
                fixed[6],  fixed[5],  fixed[4],  fixed[2]};
    end

endmodule

module ifns_decoder_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*17-1:0] req_code,
    output logic [NUM_CH-1:0]    req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [11:0]          out_data,
    output logic [CH_W-1:0]      out_ch,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     acc_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] gnt;
    logic [CH_W-1:0] gnt_lo;
    logic [CH_W-1:0] gnt_hi;
    logic            any_hi;
    logic            any_req;
    logic            can_accept;
    logic            accept;
    logic [16:0]     sel_code;
    logic [11:0]     dec_data;

    assign any_req    = |req_valid;
    assign can_accept = rst_n & ((state == EMPTY) | (out_ready & out_valid));
    assign accept     = can_accept & any_req;

    // Rotating priority: lowest requester at/after rr_ptr, else lowest overall
    always_comb begin
        gnt_lo = '0;
        gnt_hi = '0;
        any_hi = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                gnt_lo = CH_W'(j);
                if (CH_W'(j) >= rr_ptr) begin
                    gnt_hi = CH_W'(j);
                    any_hi = 1'b1;
                end
            end
        end
        gnt = any_hi ? gnt_hi : gnt_lo;
    end

    // Steer the winner's codeword into the core and raise only its ready
    always_comb begin
        sel_code  = '0;
        req_ready = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (CH_W'(j) == gnt) begin
                sel_code     = req_code[17*j +: 17];
                req_ready[j] = accept;
            end
        end
    end

    decoderIFNS_12di_core u_core (
        .code (sel_code),
        .data (dec_data)
    );

    // Output register FSM: load on accept, drain when taken with nothing new
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= dec_data;
            out_ch    <= gnt;
            rr_ptr    <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end else if (state == FULL && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

    // Saturating accepted-word counter; clear wins over a same-cycle accept
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (cnt_clr) begin
            acc_cnt <= '0;
        end else if (accept && !(&acc_cnt)) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

endmodule
